// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and op-decode helpers for muldiv_unit
package muldiv_pkg;
  typedef enum logic [1:0] {MD_MULT = 2'd0, MD_MULTU = 2'd1, MD_DIV = 2'd2, MD_DIVU = 2'd3} md_op_e;
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_RUN = 2'd1, MD_FIX = 2'd2} md_state_e;
  function automatic logic op_signed(input logic [1:0] op);
    return op inside {MD_MULT, MD_DIV};
  endfunction
  function automatic logic op_is_div(input logic [1:0] op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction
endpackage

// File: rtl/muldiv_unit_cond_neg.sv
// cond_neg: conditional two's-complement negation
//   in_i  : value
//   neg_i : negate when high
//   out_o : neg_i ? -in_i : in_i
module cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);
  assign out_o = neg_i ? -in_i : in_i;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
//   clk_i, rst_ni          : clock, async active-low reset
//   start_i, op_i, a_i, b_i : launch request (accepted only when idle)
//   mthi_i, mtlo_i, wdata_i : direct HI/LO writes (idle only, start wins)
//   hi_o, lo_o              : architectural HI/LO
//   busy_o, done_o          : op in flight / 1-cycle completion pulse
//   div_by_zero_o           : sticky until next accepted start
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(W) + 1;
  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // x: product high half / remainder; y: multiplier+low half / dividend+quotient; d: multiplicand / divisor
  logic [W-1:0] x_q, x_d, y_q, y_d, d_q, d_d, hi_q, hi_d, lo_q, lo_d;
  logic sa_q, sa_d, sb_q, sb_d, div_q, div_d, dbz_q, dbz_d;
  logic sgn, ge;
  logic [W-1:0] a_mag, b_mag, quo, rem;
  logic [W:0] sum, r_sh;
  logic [2*W-1:0] prod;
  assign sgn = op_signed(op_i);
  cond_neg #(.W(W)) u_amag (.in_i(a_i), .neg_i(sgn & a_i[W-1]), .out_o(a_mag));
  cond_neg #(.W(W)) u_bmag (.in_i(b_i), .neg_i(sgn & b_i[W-1]), .out_o(b_mag));
  cond_neg #(.W(2*W)) u_prod (.in_i({x_q, y_q}), .neg_i(sa_q ^ sb_q), .out_o(prod));
  cond_neg #(.W(W)) u_quo (.in_i(y_q), .neg_i(sa_q ^ sb_q), .out_o(quo));
  cond_neg #(.W(W)) u_rem (.in_i(x_q), .neg_i(sa_q), .out_o(rem));
  assign sum  = {1'b0, x_q} + (y_q[0] ? {1'b0, d_q} : '0);
  assign r_sh = {x_q, y_q[W-1]};
  assign ge   = r_sh >= {1'b0, d_q};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    d_d     = d_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div_d   = div_q;
    dbz_d   = dbz_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          sa_d    = sgn & a_i[W-1];
          sb_d    = sgn & b_i[W-1];
          div_d   = op_is_div(op_i);
          dbz_d   = div_d && (b_i == '0);
          cnt_d   = '0;
          // divide by zero bypasses RUN: FIX then loads HI=a, LO=all-ones untouched
          x_d     = dbz_d ? a_i : '0;
          y_d     = dbz_d ? '1 : div_d ? a_mag : b_mag;
          d_d     = div_d ? b_mag : a_mag;
          state_d = dbz_d ? MD_FIX : MD_RUN;
        end else begin
          hi_d = mthi_i ? wdata_i : hi_q;
          lo_d = mtlo_i ? wdata_i : lo_q;
        end
      end
      MD_RUN: begin
        // remainder fits in W bits after a subtract, so the W-bit difference is exact
        x_d     = div_q ? (ge ? r_sh[W-1:0] - d_q : r_sh[W-1:0]) : sum[W:1];
        y_d     = div_q ? {y_q[W-2:0], ge} : {sum[0], y_q[W-1:1]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(W - 1)) ? MD_FIX : MD_RUN;
      end
      MD_FIX: begin
        hi_d    = dbz_q ? x_q : div_q ? rem : prod[2*W-1:W];
        lo_d    = dbz_q ? y_q : div_q ? quo : prod[W-1:0];
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      d_q     <= d_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_q   <= div_d;
      dbz_q   <= dbz_d;
    end
  end
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign busy_o        = state_q != MD_IDLE;
  assign done_o        = state_q == MD_FIX;
  assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit against a 64-bit arithmetic model
module tb_muldiv_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0] op = 2'd0;
  logic [31:0] a = '0, b = '0, wdata = '0, hi, lo;
  logic busy, done, dbz;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic exp_dbz = 1'b0, cmp_en = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .mthi_i(mthi), .mtlo_i(mtlo), .wdata_i(wdata), .hi_o(hi), .lo_o(lo),
    .busy_o(busy), .done_o(done), .div_by_zero_o(dbz)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return {32'b0, x} * {32'b0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  // architectural state checked every cycle after the active edge has settled
  initial forever begin
    @(posedge clk);
    #2;
    if (cmp_en) begin
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
      chk("div_by_zero", dbz, exp_dbz);
    end
  end
  // caller sits at a negedge with the unit idle; returns at the negedge after done
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit poke, input bit mt_start);
    int n, lat;
    logic [63:0] r;
    lat = (o[1] && y == 0) ? 1 : 33;
    r = model(o, x, y);
    start = 1'b1; op = o; a = x; b = y; mthi = mt_start; wdata = $urandom;
    exp_dbz = o[1] && y == 0;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    n = 1;
    while (!done && n < 40) begin
      chk("busy_run", busy, 1);
      if (poke && n == 5) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = $urandom; b = '0;
      end
      @(negedge clk);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      n++;
    end
    chk("done_latency", n, lat);
    chk("busy_fix", busy, 1);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
  endtask
  initial begin
    logic [1:0] ro;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    do_op(2'd0, -32'sd5, 32'd3, 0, 0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);
    do_op(2'd2, -32'sd7, 32'd2, 0, 0);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    do_op(2'd3, 32'd100, 32'd7, 0, 0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h0);
    do_op(2'd3, 32'd5, 32'd0, 0, 0);
    chk("dbz_hi", hi, 32'd5);
    chk("dbz_lo", lo, 32'hFFFFFFFF);
    chk("dbz_flag", dbz, 1);
    do_op(2'd1, 32'd6, 32'd7, 1, 1);
    chk("poke_lo", lo, 32'd42);
    chk("poke_hi", hi, 32'd0);
    chk("dbz_cleared", dbz, 0);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
    exp_hi = 32'h1234; exp_lo = 32'h1234;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_hi", hi, 32'h1234);
    chk("mt_lo", lo, 32'h1234);
    start = 1'b1; op = 2'd0; a = 32'd123; b = 32'd456;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    do_op(2'd1, 32'd6, 32'd7, 0, 0);
    chk("after_abort_lo", lo, 32'd42);
    chk("after_abort_hi", hi, 32'd0);
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        mthi = 1'($urandom); mtlo = 1'($urandom); wdata = $urandom;
        if (mthi) exp_hi = wdata;
        if (mtlo) exp_lo = wdata;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
      end
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      do_op(ro, ra, rb, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    end
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
